comparator_serial: RTL and testbench

Parametrised multi-cycle magnitude comparator and the successor to the fixed 4-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per cycle.
- Supports unsigned or two's-complement signed comparison, selected per transaction.
- Optional early exit on the first differing chunk.
- Operands enter on a valid/ready start handshake. Results leave on a valid/ready result handshake. Used where wide operands make a single-cycle compare too slow.

---
 rtl/comparator_serial.sv | 127 ++++++++++++
 tb/tb_comparator_serial.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/comparator_serial.sv
// rtl/comparator_serial.sv - multi-cycle MSB-first magnitude comparator with valid/ready handshakes
module comparator_serial #(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               smode_q;
    logic [IDX_W-1:0]   idx;
    logic               diff_seen, diff_gt;
    logic [CHUNK-1:0]   ca, cb, flip;
    logic               top, last, chunk_ne, chunk_gt;
    logic               start_fire;

    // ready is gated by rst_n so it reads low for the whole reset window
    assign start_ready = rst_n && (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state == CMP);
    assign start_fire  = start_valid && start_ready;

    // Offset-binary trick: flipping the sign bit turns a signed compare into an unsigned one
    always_comb begin
        top  = (idx == IDX_W'(NCHUNK - 1));
        last = (idx == '0);
        flip = '0;
        flip[CHUNK-1] = smode_q && top;
        ca = a_q[idx*CHUNK +: CHUNK] ^ flip;
        cb = b_q[idx*CHUNK +: CHUNK] ^ flip;
        chunk_ne = (ca != cb);
        chunk_gt = (ca > cb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_fire) state_nx = CMP;
            CMP: begin
                if ((chunk_ne && (EARLY_EXIT != 0)) || last)
                    state_nx = DONE;
            end
            DONE: if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            smode_q   <= 1'b0;
            idx       <= '0;
            diff_seen <= 1'b0;
            diff_gt   <= 1'b0;
            a_eq_b    <= 1'b0;
            a_gt_b    <= 1'b0;
            a_lt_b    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fire) begin
                        a_q       <= a;
                        b_q       <= b;
                        smode_q   <= signed_mode;
                        idx       <= IDX_W'(NCHUNK - 1);
                        diff_seen <= 1'b0;
                        diff_gt   <= 1'b0;
                    end
                end
                CMP: begin
                    // Only the most significant difference decides the result
                    if (chunk_ne && !diff_seen) begin
                        diff_seen <= 1'b1;
                        diff_gt   <= chunk_gt;
                    end
                    if (state_nx == DONE) begin
                        if (diff_seen) begin
                            a_gt_b <= diff_gt;
                            a_lt_b <= !diff_gt;
                        end else if (chunk_ne) begin
                            a_gt_b <= chunk_gt;
                            a_lt_b <= !chunk_gt;
                        end else begin
                            a_eq_b <= 1'b1;
                        end
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        a_eq_b <= 1'b0;
                        a_gt_b <= 1'b0;
                        a_lt_b <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_comparator_serial.sv
// tb/tb_comparator_serial.sv - scoreboard bench for comparator_serial across three configurations
module tb_comparator_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        res_ready = 1'b1;
    logic        signed_mode = 1'b0;
    logic [15:0] a = '0, b = '0;
    int          sel = 0;

    logic sr0, rv0, eq0, gt0, lt0, bz0;
    logic sr1, rv1, eq1, gt1, lt1, bz1;
    logic sr2, rv2, eq2, gt2, lt2, bz2;
    logic sr_m, rv_m, bz_m;
    logic [2:0] fl_m;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comparator_serial #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid && sel == 0), .start_ready(sr0),
        .a(a), .b(b), .signed_mode(signed_mode), .res_valid(rv0), .res_ready(res_ready),
        .a_eq_b(eq0), .a_gt_b(gt0), .a_lt_b(lt0), .busy(bz0));

    comparator_serial #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid && sel == 1), .start_ready(sr1),
        .a(a), .b(b), .signed_mode(signed_mode), .res_valid(rv1), .res_ready(res_ready),
        .a_eq_b(eq1), .a_gt_b(gt1), .a_lt_b(lt1), .busy(bz1));

    comparator_serial #(.WIDTH(4), .CHUNK(1), .EARLY_EXIT(0)) u_legacy (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid && sel == 2), .start_ready(sr2),
        .a(a[3:0]), .b(b[3:0]), .signed_mode(signed_mode), .res_valid(rv2), .res_ready(res_ready),
        .a_eq_b(eq2), .a_gt_b(gt2), .a_lt_b(lt2), .busy(bz2));

    always_comb begin
        sr_m = sr0; rv_m = rv0; bz_m = bz0; fl_m = {eq0, gt0, lt0};
        case (sel)
            1: begin sr_m = sr1; rv_m = rv1; bz_m = bz1; fl_m = {eq1, gt1, lt1}; end
            2: begin sr_m = sr2; rv_m = rv2; bz_m = bz2; fl_m = {eq2, gt2, lt2}; end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation when a result appears, then holds it while res_valid stays high
    int         acc_cyc = 0;
    logic       prev_rv = 1'b0;
    logic [10:0] cur = '0;
    always @(negedge clk) begin
        if (start_valid && sr_m) acc_cyc = cyc;
        if (rv_m) begin
            if (!prev_rv) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got flags %b with no expectation", fl_m);
                    cur = {fl_m, 8'd0};
                end else begin
                    cur = exp_q.pop_front();
                    if (cyc - acc_cyc - 1 != int'(cur[7:0])) begin
                        n_fail++;
                        $display("FAIL latency: got %0d expected %0d", cyc - acc_cyc - 1, cur[7:0]);
                    end
                end
            end
            chk("result_flags", {29'd0, fl_m}, {29'd0, cur[10:8]});
        end
        prev_rv = rv_m;
    end

    task automatic wait_ready(input string name);
        int t = 0;
        while (!sr_m && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout waiting for start_ready", name);
        end
    endtask

    task automatic do_cmp(input int s, input logic [15:0] av, input logic [15:0] bv,
                          input logic m, input logic [2:0] ef, input int el);
        sel = s; a = av; b = bv; signed_mode = m;
        wait_ready("pre_accept");
        exp_q.push_back({ef, 8'(el)});
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        wait_ready("result_drain");
    endtask

    localparam logic [2:0] EQ = 3'b100, GT = 3'b010, LT = 3'b001;

    initial begin
        #2;
        chk("rst_start_ready", {31'd0, sr0}, 0);
        chk("rst_res_valid", {31'd0, rv0}, 0);
        chk("rst_busy", {31'd0, bz0}, 0);
        chk("rst_flags", {29'd0, eq0, gt0, lt0}, 0);
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_start_ready", {31'd0, sr0}, 1);

        do_cmp(0, 16'h1234, 16'h1234, 1'b0, EQ, 4);
        do_cmp(0, 16'h8000, 16'h7FFF, 1'b0, GT, 1);
        do_cmp(0, 16'h8000, 16'h7FFF, 1'b1, LT, 1);
        do_cmp(0, 16'h0003, 16'h0005, 1'b0, LT, 4);
        do_cmp(1, 16'h8000, 16'h7FFF, 1'b0, GT, 4);
        do_cmp(1, 16'h8000, 16'h7FFF, 1'b1, LT, 4);
        do_cmp(2, 16'd0,  16'd0,  1'b0, EQ, 4);
        do_cmp(2, 16'd5,  16'd3,  1'b0, GT, 4);
        do_cmp(2, 16'd6,  16'd6,  1'b0, EQ, 4);
        do_cmp(2, 16'd3,  16'd10, 1'b0, LT, 4);
        do_cmp(2, 16'd15, 16'd15, 1'b0, EQ, 4);

        // Backpressure, ignored start pulses and operand changes after accept
        sel = 0; a = 16'h00F0; b = 16'h00E0; signed_mode = 1'b0; res_ready = 1'b0;
        exp_q.push_back({GT, 8'd3});
        start_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h5555; b = 16'h5555; signed_mode = 1'b1;
        chk("cmp_busy", {31'd0, bz_m}, 1);
        chk("cmp_start_ready", {31'd0, sr_m}, 0);
        @(posedge clk); #1;
        start_valid = 1'b0;
        begin
            int t = 0;
            while (!rv_m && t < 20) begin @(posedge clk); #1; t++; end
            chk("bp_res_valid_seen", {31'd0, rv_m}, 1);
        end
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("done_start_ready", {31'd0, sr_m}, 0);
            chk("done_res_valid", {31'd0, rv_m}, 1);
            @(posedge clk); #1;
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_res_valid", {31'd0, rv_m}, 0);
        chk("post_hs_flags", {29'd0, fl_m}, 0);
        chk("post_hs_start_ready", {31'd0, sr_m}, 1);

        // Asynchronous reset during CMP with idx = 2
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_cmp_busy", {31'd0, bz_m}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bz_m}, 0);
        chk("abort_res_valid", {31'd0, rv_m}, 0);
        chk("abort_flags", {29'd0, fl_m}, 0);
        chk("abort_start_ready", {31'd0, sr_m}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("release_start_ready", {31'd0, sr_m}, 1);
        @(posedge clk); #1;
        do_cmp(0, 16'hFFFF, 16'h0000, 1'b1, LT, 1);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
